// File: rtl/cvxif_pau_simd.sv
// Packed-SIMD arithmetic coprocessor on the CV-X-IF issue/register/result channels.
// Accepted custom-0 instructions queue in order; each operand handshake retires the head instruction.
module cvxif_pau_simd #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned LANE_W = 8,
   parameter int unsigned DEPTH  = 4,
   parameter logic [6:0]  OPCODE = 7'b0001011
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [31:0]     issue_req_instr,
   output logic            issue_resp_accept,
   output logic            issue_resp_writeback,
   output logic [1:0]      issue_resp_register_read,
   input  logic            register_valid,
   output logic            register_ready,
   input  logic [XLEN-1:0] register_rs0,
   input  logic [XLEN-1:0] register_rs1,
   input  logic [1:0]      register_rs_valid,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result_data,
   output logic [4:0]      result_rd
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LANES = XLEN / LANE_W;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic             run;
   logic [2:0]       q_funct3 [DEPTH];
   logic [4:0]       q_rd     [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             decode_ok;
   logic             push;
   logic             fire;
   logic [XLEN-1:0]  lane_result;
   logic             unused_instr_bits;

   // run holds every handshake low until the first clock edge after reset release
   assign decode_ok = (issue_req_instr[6:0] == OPCODE) && (issue_req_instr[31:25] == 7'd0)
                      && (issue_req_instr[14:12] != 3'b111);
   assign issue_resp_accept        = run && issue_valid && decode_ok;
   assign issue_resp_writeback     = issue_resp_accept;
   assign issue_resp_register_read = {2{issue_resp_accept}};
   assign issue_ready              = run && (count < DEPTH_C);
   assign register_ready           = run && (count != '0) && (!result_valid || result_ready);
   assign push                     = issue_valid && issue_ready && decode_ok;
   assign fire                     = register_valid && register_ready && (register_rs_valid == 2'b11);
   assign unused_instr_bits        = ^issue_req_instr[24:15];

   function automatic logic [LANE_W-1:0] lane_op(input logic [2:0] op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
      logic [LANE_W:0]   sum;
      logic [LANE_W:0]   diff;
      logic [LANE_W:0]   avg;
      logic [LANE_W-1:0] smax;
      logic [LANE_W-1:0] smin;
      smax = {1'b0, {(LANE_W-1){1'b1}}};
      smin = {1'b1, {(LANE_W-1){1'b0}}};
      // one guard bit is enough to detect signed overflow of a single lane
      sum  = {a[LANE_W-1], a} + {b[LANE_W-1], b};
      diff = {a[LANE_W-1], a} - {b[LANE_W-1], b};
      avg  = {1'b0, a} + {1'b0, b} + (LANE_W + 1)'(1);
      case (op)
         3'b000:  lane_op = a + b;
         3'b001:  lane_op = a - b;
         3'b010:  lane_op = (sum[LANE_W] != sum[LANE_W-1]) ? (sum[LANE_W] ? smin : smax) : sum[LANE_W-1:0];
         3'b011:  lane_op = (diff[LANE_W] != diff[LANE_W-1]) ? (diff[LANE_W] ? smin : smax) : diff[LANE_W-1:0];
         3'b100:  lane_op = ($signed(a) < $signed(b)) ? a : b;
         3'b101:  lane_op = ($signed(a) > $signed(b)) ? a : b;
         3'b110:  lane_op = avg[LANE_W:1];
         default: lane_op = '0;
      endcase
   endfunction

   always_comb begin
      lane_result = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_result[i*LANE_W +: LANE_W] = lane_op(q_funct3[head],
                                                   register_rs0[i*LANE_W +: LANE_W],
                                                   register_rs1[i*LANE_W +: LANE_W]);
      end
   end

   // queue payload needs no reset; head/tail/count decide which entries are live
   always_ff @(posedge clk) begin
      if (push) begin
         q_funct3[tail] <= issue_req_instr[14:12];
         q_rd[tail]     <= issue_req_instr[11:7];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run          <= 1'b0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_rd    <= '0;
      end else begin
         run <= 1'b1;
         if (push) tail <= tail + 1'b1;
         if (fire) head <= head + 1'b1;
         if (push && !fire) count <= count + 1'b1;
         else if (fire && !push) count <= count - 1'b1;
         if (fire) begin
            result_valid <= 1'b1;
            result_data  <= lane_result;
            result_rd    <= q_rd[head];
         end else if (result_ready) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule
